// File: rtl/apply_iteration_controller.sv
// Apply-stage iteration sequencer: launches each iteration, gathers per-core end/update flags,
// then advances the shared iteration id or stops on convergence, iteration limit or watchdog.
module apply_iteration_controller #(
  parameter int CORE_NUM        = 4,
  parameter int ITERATION_WIDTH = 8,
  parameter int TIMEOUT_WIDTH   = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [ITERATION_WIDTH-1:0]          max_iteration,
  input  logic [TIMEOUT_WIDTH-1:0]            timeout_cycles,
  input  logic [CORE_NUM-1:0]                 core_iteration_end,
  input  logic [CORE_NUM-1:0]                 core_iteration_end_valid,
  input  logic [CORE_NUM-1:0]                 core_active_v_updated,
  input  logic [CORE_NUM-1:0]                 core_active_v_valid,
  output logic [CORE_NUM*ITERATION_WIDTH-1:0] iteration_id,
  output logic                                iteration_start,
  output logic                                iteration_done,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          status
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] ST_CONVERGED = 2'd0;
  localparam logic [1:0] ST_LIMIT     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT   = 2'd2;

  logic [2:0]                 state, state_nxt;
  logic [ITERATION_WIDTH-1:0] iter_id, iter_id_nxt;
  logic [ITERATION_WIDTH-1:0] max_iter_q, max_iter_nxt;
  logic [TIMEOUT_WIDTH-1:0]   timeout_q, timeout_nxt;
  logic [TIMEOUT_WIDTH-1:0]   wdog, wdog_nxt;
  logic [CORE_NUM-1:0]        end_mask, end_mask_nxt;
  logic [CORE_NUM-1:0]        new_ends;
  logic                       update_seen, update_seen_nxt;
  logic [1:0]                 status_q, status_nxt;
  logic                       all_ended;
  logic                       wdog_expired;
  logic [ITERATION_WIDTH-1:0] iter_id_inc;

  assign new_ends     = core_iteration_end_valid & core_iteration_end;
  assign all_ended    = &(end_mask | new_ends);
  assign wdog_expired = (timeout_q != '0) && (wdog == timeout_q - TIMEOUT_WIDTH'(1));
  assign iter_id_inc  = iter_id + ITERATION_WIDTH'(1);

  always_comb begin
    state_nxt       = state;
    iter_id_nxt     = iter_id;
    max_iter_nxt    = max_iter_q;
    timeout_nxt     = timeout_q;
    wdog_nxt        = wdog;
    end_mask_nxt    = end_mask;
    update_seen_nxt = update_seen;
    status_nxt      = status_q;

    if (abort) begin
      state_nxt       = S_IDLE;
      iter_id_nxt     = '0;
      max_iter_nxt    = '0;
      timeout_nxt     = '0;
      wdog_nxt        = '0;
      end_mask_nxt    = '0;
      update_seen_nxt = 1'b0;
      status_nxt      = ST_CONVERGED;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nxt       = S_LAUNCH;
            max_iter_nxt    = max_iteration;
            timeout_nxt     = timeout_cycles;
            iter_id_nxt     = '0;
            wdog_nxt        = '0;
            end_mask_nxt    = '0;
            update_seen_nxt = 1'b0;
            status_nxt      = ST_CONVERGED;
          end
        end
        S_LAUNCH: state_nxt = S_RUN;
        S_RUN: begin
          end_mask_nxt    = end_mask | new_ends;
          update_seen_nxt = update_seen | (|(core_active_v_updated & core_active_v_valid));
          wdog_nxt        = wdog + TIMEOUT_WIDTH'(1);
          // Completion in the same cycle as watchdog expiry takes precedence.
          if (all_ended) begin
            state_nxt = S_CHECK;
          end else if (wdog_expired) begin
            state_nxt  = S_DONE;
            status_nxt = ST_TIMEOUT;
          end
        end
        S_CHECK: begin
          if (!update_seen) begin
            state_nxt  = S_DONE;
            status_nxt = ST_CONVERGED;
          end else if ((max_iter_q != '0) && (iter_id_inc == max_iter_q)) begin
            state_nxt  = S_DONE;
            status_nxt = ST_LIMIT;
          end else if (&iter_id) begin
            state_nxt  = S_DONE;
            status_nxt = ST_LIMIT;
          end else begin
            state_nxt       = S_LAUNCH;
            iter_id_nxt     = iter_id_inc;
            wdog_nxt        = '0;
            end_mask_nxt    = '0;
            update_seen_nxt = 1'b0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Pulses and flags are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      iter_id         <= '0;
      max_iter_q      <= '0;
      timeout_q       <= '0;
      wdog            <= '0;
      end_mask        <= '0;
      update_seen     <= 1'b0;
      status_q        <= ST_CONVERGED;
      iteration_start <= 1'b0;
      iteration_done  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      iter_id         <= iter_id_nxt;
      max_iter_q      <= max_iter_nxt;
      timeout_q       <= timeout_nxt;
      wdog            <= wdog_nxt;
      end_mask        <= end_mask_nxt;
      update_seen     <= update_seen_nxt;
      status_q        <= status_nxt;
      iteration_start <= (state_nxt == S_LAUNCH);
      iteration_done  <= (state_nxt == S_CHECK);
      busy            <= (state_nxt == S_LAUNCH) || (state_nxt == S_RUN) || (state_nxt == S_CHECK);
      done            <= (state_nxt == S_DONE);
    end
  end

  assign iteration_id = {CORE_NUM{iter_id}};
  assign status       = status_q;

endmodule

// File: tb/tb_apply_iteration_controller.sv
// Bench for apply_iteration_controller: randomized per-core end/update timing checked against
// an iteration-level model of when each run should finish and why.
module tb_apply_iteration_controller;
  localparam int CN = 4;
  localparam int IW = 3;
  localparam int TW = 24;

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [IW-1:0]    max_iteration;
  logic [TW-1:0]    timeout_cycles;
  logic [CN-1:0]    core_iteration_end, core_iteration_end_valid;
  logic [CN-1:0]    core_active_v_updated, core_active_v_valid;
  logic [CN*IW-1:0] iteration_id;
  logic             iteration_start, iteration_done, busy, done;
  logic [1:0]       status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apply_iteration_controller #(
    .CORE_NUM(CN), .ITERATION_WIDTH(IW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .max_iteration(max_iteration), .timeout_cycles(timeout_cycles),
    .core_iteration_end(core_iteration_end), .core_iteration_end_valid(core_iteration_end_valid),
    .core_active_v_updated(core_active_v_updated), .core_active_v_valid(core_active_v_valid),
    .iteration_id(iteration_id), .iteration_start(iteration_start),
    .iteration_done(iteration_done), .busy(busy), .done(done), .status(status)
  );

  function automatic logic [CN*IW-1:0] rep(input int v);
    logic [IW-1:0] s;
    s = IW'(v);
    return {CN{s}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic s, input logic dit, input logic b,
                             input logic dn, input logic [1:0] st, input int id);
    check({tag, ".iteration_start"}, 32'(iteration_start), 32'(s));
    check({tag, ".iteration_done"}, 32'(iteration_done), 32'(dit));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".status"}, 32'(status), 32'(st));
    check({tag, ".iteration_id"}, 32'(iteration_id), 32'(rep(id)));
  endtask

  task automatic quiet_inputs();
    start = 1'b0;
    abort = 1'b0;
    core_iteration_end = '0;
    core_iteration_end_valid = '0;
    core_active_v_updated = '0;
    core_active_v_valid = '0;
  endtask

  // Random flag noise where only the forced bits carry a qualified end / update.
  task automatic drive_noise(input logic [CN-1:0] force_end, input logic force_upd);
    logic [CN-1:0] r1, r2, r3, r4, uk;
    r1 = CN'($urandom);
    r2 = CN'($urandom);
    r3 = CN'($urandom);
    r4 = CN'($urandom);
    uk = '0;
    if (force_upd) uk[$urandom_range(0, CN-1)] = 1'b1;
    core_iteration_end_valid = r1 | force_end;
    core_iteration_end       = (r2 & ~r1) | force_end;
    core_active_v_valid      = r3 | uk;
    core_active_v_updated    = (r4 & ~r3) | uk;
    start                    = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at a negedge with the DUT in IDLE or DONE.
  task automatic run_session(input string tag, input int max_it, input int tmo,
                             input int noupd_at, input int hang_at, input int fix_last);
    int id, last_end, upd_cyc, run_len, kk;
    int end_at[CN];
    bit with_upd, timed_out, finished;
    logic [CN-1:0] fm;
    logic [1:0] exp_st;

    quiet_inputs();
    start = 1'b1;
    max_iteration = IW'(max_it);
    timeout_cycles = TW'(tmo);
    @(negedge clk);
    start = 1'b0;
    max_iteration = IW'($urandom);
    timeout_cycles = TW'($urandom_range(1, 3));
    id = 0;
    finished = 1'b0;
    for (int guard = 0; guard < 16 && !finished; guard++) begin
      expect_outs({tag, ".launch"}, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, id);
      core_iteration_end = '1;
      core_iteration_end_valid = '1;
      core_active_v_updated = '1;
      core_active_v_valid = '1;
      @(negedge clk);

      with_upd = (id != noupd_at);
      if (fix_last != 0) last_end = fix_last;
      else if (tmo != 0) last_end = $urandom_range(1, tmo);
      else last_end = $urandom_range(1, 10);
      foreach (end_at[k]) end_at[k] = $urandom_range(1, last_end);
      if (fix_last != 0) begin
        end_at[0] = (last_end >= 2) ? 2 : 1;
        end_at[CN-1] = last_end;
      end else begin
        end_at[$urandom_range(0, CN-1)] = last_end;
      end
      if (tmo != 0 && id == hang_at) begin
        kk = $urandom_range(0, CN-1);
        end_at[kk] = 1000;
        last_end = 1000;
      end
      upd_cyc = (id == 0) ? last_end : $urandom_range(1, last_end);
      timed_out = (tmo != 0) && (last_end > tmo);
      run_len = timed_out ? tmo : last_end;

      for (int c = 1; c <= run_len; c++) begin
        expect_outs({tag, ".run"}, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, id);
        fm = '0;
        for (int k = 0; k < CN; k++) fm[k] = (end_at[k] == c);
        drive_noise(fm, with_upd && (c == upd_cyc));
        @(negedge clk);
      end
      quiet_inputs();

      if (timed_out) begin
        expect_outs({tag, ".timeout"}, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, id);
        finished = 1'b1;
      end else begin
        expect_outs({tag, ".check"}, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, id);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!with_upd) begin
          exp_st = 2'd0;
          finished = 1'b1;
        end else if (max_it != 0 && id + 1 == max_it) begin
          exp_st = 2'd1;
          finished = 1'b1;
        end else if (id == (1 << IW) - 1) begin
          exp_st = 2'd1;
          finished = 1'b1;
        end else begin
          exp_st = 2'd0;
          id++;
        end
        if (finished) expect_outs({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1, exp_st, id);
      end
    end
    check({tag, ".terminated"}, 32'(finished), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    max_iteration = '0;
    timeout_cycles = '0;
    #2 rst = 1'b0;
    #2 expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);

    run_session("lim3", 3, 0, -1, -1, 0);
    run_session("stagger", 2, 0, -1, -1, 9);
    run_session("noupd", 0, 0, 1, -1, 0);
    run_session("tmo_first", 0, 5, -1, 0, 0);
    run_session("tmo_second", 0, 5, -1, 1, 0);
    run_session("tmo_edge", 0, 5, 2, -1, 5);
    run_session("id_saturate", 0, 0, -1, -1, 0);

    // Abort from DONE clears the held id and status.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_outs("abort_done", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);

    // Abort together with start mid-run.
    run_session("pre_abort", 2, 0, -1, -1, 0);
    start = 1'b1;
    max_iteration = '0;
    timeout_cycles = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_iteration_end = 4'b0011;
    core_iteration_end_valid = 4'b0011;
    @(negedge clk);
    expect_outs("abort_pre", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    quiet_inputs();
    expect_outs("abort_run", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    @(negedge clk);
    expect_outs("abort_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    run_session("post_abort", 2, 0, -1, -1, 0);

    for (int r = 0; r < 6; r++) begin
      int mx, tm, nu, hg;
      mx = $urandom_range(0, 7);
      tm = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 8) : 0;
      nu = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : -1;
      hg = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
      run_session("random", mx, tm, nu, hg, 0);
    end

    // Asynchronous reset between edges in the middle of RUN.
    start = 1'b1;
    max_iteration = '0;
    timeout_cycles = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_iteration_end = 4'b0111;
    core_iteration_end_valid = 4'b0111;
    core_active_v_updated = 4'b0001;
    core_active_v_valid = 4'b0001;
    @(negedge clk);
    expect_outs("rst_pre", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 expect_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    @(negedge clk);
    core_iteration_end = '1;
    core_iteration_end_valid = '1;
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    end
    quiet_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apply_iteration_controller.md
Name: apply_iteration_controller

Overview:
Global iteration sequencer for the apply stage. It launches each iteration, gathers per-core iteration-end flags and per-core vertex-update activity from the apply stage outputs, and decides when the whole array has finished the iteration. It then advances the shared iteration id or terminates on convergence, iteration limit or watchdog timeout. It sits beside the apply iteration-end stage and drives the iteration id and start pulse that all cores consume.

Parameters:
CORE_NUM, `CORE_NUM, number of cores (bit width of per-core vectors)
ITERATION_WIDTH, `ITERATION_WIDTH, width of the iteration id
TIMEOUT_WIDTH, 24, width of the per-iteration watchdog counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
start  input  1  one-cycle request to begin a run; honoured in IDLE and DONE only
abort  input  1  synchronous abort; returns the FSM to IDLE from any state
max_iteration  input  ITERATION_WIDTH  iteration limit, sampled on start; 0 means unlimited
timeout_cycles  input  TIMEOUT_WIDTH  per-iteration watchdog limit, sampled on start; 0 disables the watchdog
core_iteration_end  input  CORE_NUM  per-core end flag
core_iteration_end_valid  input  CORE_NUM  per-core end-flag qualifier
core_active_v_updated  input  CORE_NUM  per-core vertex-updated flag
core_active_v_valid  input  CORE_NUM  per-core update qualifier
iteration_id  output  CORE_NUM*ITERATION_WIDTH  current iteration id, replicated per core
iteration_start  output  1  one-cycle pulse at the launch of each iteration
iteration_done  output  1  one-cycle pulse when all cores have ended the current iteration
busy  output  1  high in LAUNCH, RUN and CHECK
done  output  1  high in DONE
status  output  2  termination cause, valid while done: 0 converged, 1 limit, 2 timeout

Behaviour:
- Reset (rst=0, asynchronous) puts the block in IDLE. All outputs are 0. end_mask, update_seen and the watchdog counter are 0.
- FSM states: IDLE, LAUNCH, RUN, CHECK, DONE. All outputs are registered.
- IDLE/DONE with start=1:
  - Latch max_iteration and timeout_cycles.
  - iteration_id <= 0; clear end_mask, update_seen, watchdog and status.
  - Next state LAUNCH. In DONE, done drops in the same cycle.
- LAUNCH: lasts 1 cycle. iteration_start=1 while in this state, then RUN.
- RUN:
  - end_mask[i] is set when core_iteration_end_valid[i] & core_iteration_end[i]. Set bits stay set.
  - update_seen is ORed with |(core_active_v_updated & core_active_v_valid).
  - The watchdog increments every RUN cycle.
  - Completion: when (end_mask | this cycle's new ends) is all ones, go to CHECK on the next edge. Updates arriving in that same cycle are still counted.
  - Timeout: if timeout_cycles != 0 and watchdog == timeout_cycles - 1 without completion, go to DONE with status=2. Completion in the same cycle wins over timeout.
- CHECK: lasts 1 cycle. iteration_done=1. Conditions are evaluated in this order:
  1. update_seen == 0: go to DONE, status=0.
  2. max_iteration != 0 and iteration_id + 1 == max_iteration: go to DONE, status=1.
  3. iteration_id is all ones: go to DONE, status=1 (no wrap-around).
  4. Otherwise: iteration_id + 1, clear end_mask, update_seen and watchdog, go to LAUNCH.
- Latency:
  - start to iteration_start is 1 cycle.
  - The last core end to iteration_done is 1 cycle.
  - iteration_done to the next iteration_start is 1 cycle.
- Input handling in non-RUN states: per-core inputs outside RUN are ignored, including ends that arrive in LAUNCH. start outside IDLE/DONE is ignored.
- abort=1: next state IDLE from any state, with all outputs and internal state cleared as at reset. abort has priority over start in the same cycle.
- iteration_id holds its value in DONE until the next start. The same value is driven on all CORE_NUM slices.

Test Plan:
- CORE_NUM cores; start, then in every iteration all cores end in the same cycle with an update seen; max_iteration=3 -> iteration_start pulses 3 times, iteration_id goes 0,1,2, then done=1 with status=1 and iteration_id held at 2.
- Cores end staggered: core 0 at RUN cycle 2, the last core at cycle 9, updates present -> iteration_done exactly 1 cycle after cycle 9, next iteration_start 1 cycle after that.
- Iteration 1 has no valid updates (updated=1 with valid=0 only), max_iteration=0 -> after iteration 1, done=1, status=0, iteration_id=1.
- timeout_cycles=5, one core never ends -> done=1 and status=2 after 5 RUN cycles. A variant where the last end arrives in the 5th cycle -> CHECK is taken, no timeout.
- abort asserted mid-RUN together with start -> IDLE with all outputs 0; a later start restarts from iteration_id=0.
- rst pulsed low asynchronously mid-RUN, between clock edges -> outputs go to 0 immediately; no iteration_done pulse after release.
